// File: rtl/cpu_types.sv
// Shared CPU types: opcodes, the task payload carried down the pipe,
// and the issue-queue classification helper.
package cpu_types;

  typedef enum logic [2:0] {
    OP_ALU    = 3'd0,
    OP_LOAD   = 3'd1,
    OP_STORE  = 3'd2,
    OP_BRANCH = 3'd3,
    OP_MUL    = 3'd4
  } opcode_t;

  typedef struct packed {
    opcode_t    opcode;
    logic [7:0] tag;
    logic [7:0] data;
  } task_t;

  typedef enum logic [1:0] {
    IQ_STORE,
    IQ_LOAD,
    IQ_ALU
  } iq_class_t;

  // Anything that is neither a store nor a load goes to the ALU stations.
  function automatic iq_class_t iq_classify(input opcode_t opcode);
    case (opcode)
      OP_STORE: return IQ_STORE;
      OP_LOAD:  return IQ_LOAD;
      default:  return IQ_ALU;
    endcase
  endfunction

endpackage

// File: rtl/issue_queue_param_rs_select.sv
// Finds the lowest-index free reservation station in the window
// [BASE, BASE+SIZE) of the global RS_BUSY vector.
module issue_queue_param_rs_select #(
  parameter int unsigned N_RS = 6,
  parameter int unsigned BASE = 0,
  parameter int unsigned SIZE = 2
) (
  input  logic [N_RS-1:0] busy,
  output logic            found,
  output logic [N_RS-1:0] target
);

  localparam int unsigned IW = $clog2(N_RS);

  always_comb begin
    found  = 1'b0;
    target = '0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      if (!found && !busy[IW'(BASE + i)]) begin
        found                = 1'b1;
        target[IW'(BASE + i)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/issue_queue_param.sv
// In-order dual-enqueue issue queue feeding class-partitioned reservation stations.
// Optional macro IQ_STALL_STATS_EN adds saturating STALL_CNT / FULL_CNT counters.
module issue_queue_param
  import cpu_types::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned N_STORE_RS = 2,
  parameter int unsigned N_LOAD_RS  = 2,
  parameter int unsigned N_ALU_RS   = 2,
  localparam int unsigned N_RS = N_STORE_RS + N_LOAD_RS + N_ALU_RS,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = PW + 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            FLUSH,
  input  task_t           TASK_0,
  input  logic            TASK_0_VALID,
  input  task_t           TASK_1,
  input  logic            TASK_1_VALID,
  output logic            ENQ_ACCEPT,
  input  logic [N_RS-1:0] RS_BUSY,
  output logic            DISPATCH_VALID,
  output task_t           DISPATCH_TASK,
  output logic [N_RS-1:0] DISPATCH_RS,
  output logic            FULL,
  output logic            EMPTY,
  output logic [CW-1:0]   COUNT
`ifdef IQ_STALL_STATS_EN
  ,
  output logic [31:0]     STALL_CNT,
  output logic [31:0]     FULL_CNT
`endif
);

  if (N_STORE_RS == 0 || N_LOAD_RS == 0 || N_ALU_RS == 0 ||
      DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("issue_queue_param: illegal configuration");
  end

  task_t           mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;
  logic [1:0]      n_in;
  logic [CW-1:0]   free;
  iq_class_t       head_class;
  logic            found_st, found_ld, found_alu, sel_found;
  logic [N_RS-1:0] tgt_st, tgt_ld, tgt_alu, sel_tgt;

  // Free space is judged on start-of-cycle occupancy; a same-cycle dispatch is not credited.
  assign n_in       = {1'b0, TASK_0_VALID} + {1'b0, TASK_1_VALID};
  assign free       = CW'(DEPTH) - count;
  assign ENQ_ACCEPT = !RST && !FLUSH && (n_in != 2'd0) && (free >= CW'(n_in));

  assign EMPTY = (count == '0);
  assign FULL  = (free < CW'(2));
  assign COUNT = count;

  assign DISPATCH_TASK = EMPTY ? '0 : mem[head];
  assign head_class    = iq_classify(DISPATCH_TASK.opcode);

  issue_queue_param_rs_select #(.N_RS(N_RS), .BASE(0), .SIZE(N_STORE_RS)) u_sel_store (
    .busy(RS_BUSY), .found(found_st), .target(tgt_st)
  );
  issue_queue_param_rs_select #(.N_RS(N_RS), .BASE(N_STORE_RS), .SIZE(N_LOAD_RS)) u_sel_load (
    .busy(RS_BUSY), .found(found_ld), .target(tgt_ld)
  );
  issue_queue_param_rs_select #(.N_RS(N_RS), .BASE(N_STORE_RS + N_LOAD_RS), .SIZE(N_ALU_RS)) u_sel_alu (
    .busy(RS_BUSY), .found(found_alu), .target(tgt_alu)
  );

  always_comb begin
    sel_found = 1'b0;
    sel_tgt   = '0;
    case (head_class)
      IQ_STORE: begin sel_found = found_st;  sel_tgt = tgt_st;  end
      IQ_LOAD:  begin sel_found = found_ld;  sel_tgt = tgt_ld;  end
      default:  begin sel_found = found_alu; sel_tgt = tgt_alu; end
    endcase
  end

  assign DISPATCH_VALID = !RST && !EMPTY && !FLUSH && sel_found;
  assign DISPATCH_RS    = DISPATCH_VALID ? sel_tgt : '0;

  // Pointer and occupancy state; flush outranks enqueue and dispatch.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (FLUSH) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (DISPATCH_VALID) head <= head + PW'(1);
      if (ENQ_ACCEPT)     tail <= tail + PW'(n_in);
      count <= count + (ENQ_ACCEPT ? CW'(n_in) : CW'(0)) - (DISPATCH_VALID ? CW'(1) : CW'(0));
    end
  end

  // Entry storage needs no reset; a lone TASK_1 lands at tail.
  always_ff @(posedge CLK) begin
    if (ENQ_ACCEPT) begin
      if (TASK_0_VALID) mem[tail] <= TASK_0;
      if (TASK_1_VALID) mem[tail + PW'(TASK_0_VALID)] <= TASK_1;
    end
  end

`ifdef IQ_STALL_STATS_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      STALL_CNT <= '0;
      FULL_CNT  <= '0;
    end else begin
      if (!EMPTY && !DISPATCH_VALID && !FLUSH && STALL_CNT != '1)
        STALL_CNT <= STALL_CNT + 32'd1;
      if (n_in != 2'd0 && !ENQ_ACCEPT && FULL_CNT != '1)
        FULL_CNT <= FULL_CNT + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_issue_queue_param.sv
// Self-checking bench for issue_queue_param: directed vector table plus a
// queue-based reference model driving reset, fill, wrap, flush and stall sequences.
module tb_issue_queue_param;
  import cpu_types::*;

  localparam int DEPTH = 16;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        FLUSH = 1'b0;
  task_t       TASK_0 = '0;
  task_t       TASK_1 = '0;
  logic        TASK_0_VALID = 1'b0;
  logic        TASK_1_VALID = 1'b0;
  logic [5:0]  RS_BUSY = '0;
  logic        ENQ_ACCEPT;
  logic        DISPATCH_VALID;
  task_t       DISPATCH_TASK;
  logic [5:0]  DISPATCH_RS;
  logic        FULL;
  logic        EMPTY;
  logic [4:0]  COUNT;
`ifdef IQ_STALL_STATS_EN
  logic [31:0] STALL_CNT;
  logic [31:0] FULL_CNT;
`endif

  issue_queue_param dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
    .TASK_0(TASK_0), .TASK_0_VALID(TASK_0_VALID),
    .TASK_1(TASK_1), .TASK_1_VALID(TASK_1_VALID),
    .ENQ_ACCEPT(ENQ_ACCEPT), .RS_BUSY(RS_BUSY),
    .DISPATCH_VALID(DISPATCH_VALID), .DISPATCH_TASK(DISPATCH_TASK),
    .DISPATCH_RS(DISPATCH_RS), .FULL(FULL), .EMPTY(EMPTY), .COUNT(COUNT)
`ifdef IQ_STALL_STATS_EN
    , .STALL_CNT(STALL_CNT), .FULL_CNT(FULL_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  int          vec_cnt = 0;
  int          err_cnt = 0;
  task_t       model_q[$];
  int unsigned stall_model = 0;
  int unsigned full_model  = 0;
  logic [7:0]  ntag = 8'd100;

  typedef struct {
    task_t      t0;
    logic       v0;
    task_t      t1;
    logic       v1;
    logic [5:0] busy;
    logic       acc;
    logic       dv;
    logic [5:0] rs;
    logic [4:0] cnt;
    logic [7:0] tag;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic task_t mk(input opcode_t op, input logic [7:0] tag);
    task_t t;
    t.opcode = op;
    t.tag    = tag;
    t.data   = tag ^ 8'h5A;
    return t;
  endfunction

  function automatic task_t rnd_task();
    ntag = ntag + 8'd1;
    return mk(opcode_t'($urandom_range(0, 4)), ntag);
  endfunction

  function automatic vec_t mv(input task_t t0, input logic v0, input task_t t1, input logic v1,
                              input logic [5:0] busy, input logic acc, input logic dv,
                              input logic [5:0] rs, input logic [4:0] cnt, input logic [7:0] tag);
    vec_t v;
    v.t0 = t0; v.v0 = v0; v.t1 = t1; v.v1 = v1; v.busy = busy;
    v.acc = acc; v.dv = dv; v.rs = rs; v.cnt = cnt; v.tag = tag;
    return v;
  endfunction

  // Reference target: stores own RS 0-1, loads 2-3, everything else 4-5.
  function automatic logic [5:0] model_rs(input task_t t, input logic [5:0] busy);
    int base;
    logic [5:0] r;
    r = '0;
    if (t.opcode == OP_STORE)     base = 0;
    else if (t.opcode == OP_LOAD) base = 2;
    else                          base = 4;
    if (!busy[base])          r[base] = 1'b1;
    else if (!busy[base + 1]) r[base + 1] = 1'b1;
    return r;
  endfunction

  // One cycle: drive, compare against the model, clock, then update the model.
  task automatic step(input task_t t0, input logic v0, input task_t t1, input logic v1,
                      input logic [5:0] busy, input logic flush);
    int         sz, n;
    logic       exp_acc, exp_dv;
    logic [5:0] exp_rs;
    task_t      exp_task;
    TASK_0 = t0; TASK_0_VALID = v0; TASK_1 = t1; TASK_1_VALID = v1;
    RS_BUSY = busy; FLUSH = flush;
    #2;
    sz       = model_q.size();
    n        = int'(v0) + int'(v1);
    exp_acc  = (n > 0) && (DEPTH - sz >= n) && !flush;
    exp_task = (sz > 0) ? model_q[0] : '0;
    exp_rs   = (sz > 0 && !flush) ? model_rs(exp_task, busy) : 6'd0;
    exp_dv   = (exp_rs != 6'd0);
    check("count", COUNT, sz);
    check("empty", EMPTY, sz == 0);
    check("full", FULL, (DEPTH - sz) < 2);
    check("enq_accept", ENQ_ACCEPT, exp_acc);
    check("dispatch_valid", DISPATCH_VALID, exp_dv);
    check("dispatch_rs", DISPATCH_RS, exp_rs);
    check("dispatch_task", DISPATCH_TASK, exp_task);
    if (sz > 0 && !exp_dv && !flush) stall_model++;
    if (n > 0 && !exp_acc) full_model++;
    @(posedge CLK);
    if (flush) model_q.delete();
    else begin
      if (exp_dv) void'(model_q.pop_front());
      if (exp_acc) begin
        if (v0) model_q.push_back(t0);
        if (v1) model_q.push_back(t1);
      end
    end
    #1;
`ifdef IQ_STALL_STATS_EN
    check("stall_cnt", STALL_CNT, stall_model);
    check("full_cnt", FULL_CNT, full_model);
`endif
  endtask

  task automatic idle(input logic [5:0] busy);
    step('0, 1'b0, '0, 1'b0, busy, 1'b0);
  endtask

  task automatic pair(input logic [5:0] busy);
    task_t a, b;
    a = rnd_task();
    b = rnd_task();
    step(a, 1'b1, b, 1'b1, busy, 1'b0);
  endtask

  initial begin
    task_t z;
    z = '0;
    vecs[0]  = mv(z, 0, z, 0, 6'b000000, 0, 0, 6'b000000, 0, 0);
    vecs[1]  = mv(mk(OP_STORE, 1), 1, mk(OP_LOAD, 2), 1, 6'b000000, 1, 0, 6'b000000, 0, 0);
    vecs[2]  = mv(z, 0, z, 0, 6'b000000, 0, 1, 6'b000001, 2, 1);
    vecs[3]  = mv(z, 0, z, 0, 6'b000000, 0, 1, 6'b000100, 1, 2);
    vecs[4]  = mv(mk(OP_MUL, 3), 1, mk(OP_LOAD, 4), 1, 6'b000000, 1, 0, 6'b000000, 0, 0);
    vecs[5]  = mv(z, 0, z, 0, 6'b110000, 0, 0, 6'b000000, 2, 0);
    vecs[6]  = mv(z, 0, z, 0, 6'b110000, 0, 0, 6'b000000, 2, 0);
    vecs[7]  = mv(z, 0, z, 0, 6'b010000, 0, 1, 6'b100000, 2, 3);
    vecs[8]  = mv(z, 0, z, 0, 6'b000000, 0, 1, 6'b000100, 1, 4);
    vecs[9]  = mv(mk(OP_STORE, 6), 1, mk(OP_STORE, 7), 1, 6'b000000, 1, 0, 6'b000000, 0, 0);
    vecs[10] = mv(z, 0, z, 0, 6'b000001, 0, 1, 6'b000010, 2, 6);
    vecs[11] = mv(z, 0, z, 0, 6'b000011, 0, 0, 6'b000000, 1, 0);
    vecs[12] = mv(z, 0, z, 0, 6'b000000, 0, 1, 6'b000001, 1, 7);
    vecs[13] = mv(z, 0, mk(OP_LOAD, 8), 1, 6'b000000, 1, 0, 6'b000000, 0, 0);
    vecs[14] = mv(z, 0, z, 0, 6'b000100, 0, 1, 6'b001000, 1, 8);
    vecs[15] = mv(z, 0, z, 0, 6'b000000, 0, 0, 6'b000000, 0, 0);

    // Reset state, with a valid offer present while reset is held.
    TASK_0_VALID = 1'b1;
    TASK_1_VALID = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("rst.empty", EMPTY, 1'b1);
    check("rst.count", COUNT, 0);
    check("rst.full", FULL, 1'b0);
    check("rst.dispatch_valid", DISPATCH_VALID, 1'b0);
    check("rst.dispatch_rs", DISPATCH_RS, 0);
    check("rst.enq_accept", ENQ_ACCEPT, 1'b0);
    check("rst.dispatch_task", DISPATCH_TASK, 0);
    TASK_0_VALID = 1'b0;
    TASK_1_VALID = 1'b0;
    RST = 1'b0;

    // Directed vector table: ordering, class targeting, in-order stall.
    for (int i = 0; i < NV; i++) begin
      TASK_0 = vecs[i].t0; TASK_0_VALID = vecs[i].v0;
      TASK_1 = vecs[i].t1; TASK_1_VALID = vecs[i].v1;
      RS_BUSY = vecs[i].busy; FLUSH = 1'b0;
      #2;
      check($sformatf("vec%0d.enq_accept", i), ENQ_ACCEPT, vecs[i].acc);
      check($sformatf("vec%0d.dispatch_valid", i), DISPATCH_VALID, vecs[i].dv);
      check($sformatf("vec%0d.dispatch_rs", i), DISPATCH_RS, vecs[i].rs);
      check($sformatf("vec%0d.count", i), COUNT, vecs[i].cnt);
      check($sformatf("vec%0d.empty", i), EMPTY, vecs[i].cnt == 5'd0);
      if (vecs[i].dv) check($sformatf("vec%0d.tag", i), DISPATCH_TASK.tag, vecs[i].tag);
      else if (vecs[i].cnt == 5'd0) check($sformatf("vec%0d.zero_task", i), DISPATCH_TASK, 0);
      @(posedge CLK);
      #1;
    end

    // Asynchronous reset mid-burst discards entries without a clock edge.
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    stall_model = 0;
    full_model  = 0;
    pair(6'h3F);
    pair(6'h3F);
    TASK_0_VALID = 1'b1; TASK_1_VALID = 1'b1; RS_BUSY = '0;
    #1;
    RST = 1'b1;
    #1;
    check("amid.empty", EMPTY, 1'b1);
    check("amid.count", COUNT, 0);
    check("amid.dispatch_valid", DISPATCH_VALID, 1'b0);
    check("amid.enq_accept", ENQ_ACCEPT, 1'b0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    model_q.delete();
    stall_model = 0;
    full_model  = 0;
    idle(6'h00);
    idle(6'h00);

    // Fill to 15, dual offer refused, single TASK_1 accepted to 16.
    for (int i = 0; i < 7; i++) pair(6'h3F);
    step(rnd_task(), 1'b1, '0, 1'b0, 6'h3F, 1'b0);
    pair(6'h3F);
    step('0, 1'b0, rnd_task(), 1'b1, 6'h3F, 1'b0);
    idle(6'h3F);

    // Drain to 4, then dual enqueue with dispatch, then random traffic across the wrap.
    for (int i = 0; i < 12; i++) idle(6'h00);
    pair(6'h00);
    for (int i = 0; i < 60; i++) begin
      task_t a, b;
      logic [1:0] v;
      a = rnd_task();
      b = rnd_task();
      v = 2'($urandom_range(0, 3));
      step(a, v[0], b, v[1], 6'($urandom_range(0, 63)), 1'b0);
    end

    // Flush at 9 with valid inputs present.
    step('0, 1'b0, '0, 1'b0, 6'h00, 1'b1);
    for (int i = 0; i < 4; i++) pair(6'h3F);
    step(rnd_task(), 1'b1, '0, 1'b0, 6'h3F, 1'b0);
    step(rnd_task(), 1'b1, rnd_task(), 1'b1, 6'h00, 1'b1);
    idle(6'h00);

    // Dual enqueue plus dispatch at DEPTH-2, then drain.
    for (int i = 0; i < 7; i++) pair(6'h3F);
    pair(6'h00);
    idle(6'h3F);
    for (int i = 0; i < 17; i++) idle(6'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
